// File: rtl/piso_ser.sv
// Parallel-in serial-out serializer with valid/ready load and MSB-first output.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_ser #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [n-1:0] din,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         last
);

`ifdef PISO_PARITY_EN
    localparam int L = n + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
    localparam int L = n;
    typedef enum logic {IDLE, SHIFT} state_t;
`endif
    localparam int CW = $clog2(n + 1);

    state_t         state;
    logic [n-1:0]   shreg;
    logic [CW-1:0]  cnt;
    logic           accept;
`ifdef PISO_PARITY_EN
    logic           par;
`endif

    // A new word can be taken while idle or on the final bit, giving gapless frames.
    assign load_ready = (state == IDLE) || last;
    assign accept     = load_valid && load_ready;

    // cnt holds the number of frame bits still to come after the one on sout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            cnt        <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            last       <= 1'b0;
`ifdef PISO_PARITY_EN
            par        <= 1'b0;
`endif
        end else if (accept) begin
            state      <= SHIFT;
            shreg      <= {din[n-2:0], 1'b0};
            cnt        <= CW'(L - 1);
            sout       <= din[n-1];
            sout_valid <= 1'b1;
            last       <= 1'b0;
`ifdef PISO_PARITY_EN
            par        <= ^din;
`endif
        end else begin
            case (state)
                IDLE: begin
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    last       <= 1'b0;
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        state      <= IDLE;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        last       <= 1'b0;
                    end else begin
                        cnt  <= cnt - 1'b1;
                        last <= (cnt == CW'(1));
`ifdef PISO_PARITY_EN
                        if (cnt == CW'(1)) begin
                            state <= PAR;
                            sout  <= par;
                        end else begin
                            sout  <= shreg[n-1];
                            shreg <= {shreg[n-2:0], 1'b0};
                        end
`else
                        sout  <= shreg[n-1];
                        shreg <= {shreg[n-2:0], 1'b0};
`endif
                    end
                end
`ifdef PISO_PARITY_EN
                PAR: begin
                    state      <= IDLE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    last       <= 1'b0;
                end
`endif
                default: begin
                    state      <= IDLE;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    last       <= 1'b0;
                end
            endcase
        end
    end

endmodule
